// File: rtl/parity_frame_accum_if.sv
// Word-in / frame-result handshake bundle for parity_frame_accum.
// master = word source and result consumer; slave = the accumulator.
interface parity_frame_accum_if #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int FCW       = 16
);
    localparam int CW = $clog2(FRAME_LEN + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic             out_parity;
    logic [CW-1:0]    out_words;
    logic [FCW-1:0]   frame_cnt;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_parity,
        input  out_words,
        input  frame_cnt
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_parity,
        output out_words,
        output frame_cnt
    );
endinterface

// File: rtl/parity_frame_accum.sv
// Running XOR parity over WIDTH-bit words, grouped into frames of up to
// FRAME_LEN words, with one registered result per frame.
module parity_frame_accum #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 4,
    parameter int ODD       = 0,
    parameter int FCW       = 16
) (
    input  logic                clk,
    input  logic                rst,
    parity_frame_accum_if.slave bus
);
    localparam int            CW       = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
    localparam logic          ODD_BIT  = (ODD != 0);

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]     r_state;
    logic           r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_parity;
    logic [CW-1:0]  r_words;
    logic           r_valid;
    logic [FCW-1:0] r_frame_cnt;

    logic w_in_ready;
    logic w_accept;
    logic w_word_par;
    logic w_end;
    logic w_hs;

    // in_ready depends on registered state only, so no input reaches it
    assign w_in_ready = (r_state == ST_ACC);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_word_par = ^bus.in_data;
    assign w_end      = (r_cnt == LAST_IDX) || bus.in_last;
    assign w_hs       = r_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_ACC;
            r_acc       <= 1'b0;
            r_cnt       <= '0;
            r_parity    <= 1'b0;
            r_words     <= '0;
            r_valid     <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            unique case (r_state)
                ST_ACC: begin
                    if (w_accept && w_end) begin
                        r_state  <= ST_HOLD;
                        r_parity <= r_acc ^ w_word_par ^ ODD_BIT;
                        r_words  <= r_cnt + CW'(1);
                        r_valid  <= 1'b1;
                        r_acc    <= 1'b0;
                        r_cnt    <= '0;
                    end else if (w_accept) begin
                        r_acc <= r_acc ^ w_word_par;
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_HOLD: begin
                    // no bypass: the next word waits for the cycle after this
                    if (w_hs) begin
                        r_state     <= ST_ACC;
                        r_valid     <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + FCW'(1);
                    end
                end
                default: begin
                    r_state <= ST_ACC;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_valid;
    assign bus.out_parity = r_parity;
    assign bus.out_words  = r_words;
    assign bus.frame_cnt  = r_frame_cnt;
endmodule

// File: tb/tb_parity_frame_accum.sv
// Bench for parity_frame_accum: three configurations behind one driver,
// fixed vectors, hand sequences and randomized frames against a model.
module tb_parity_frame_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    parity_frame_accum_if #(.WIDTH(8), .FRAME_LEN(4), .FCW(16)) ifa ();
    parity_frame_accum_if #(.WIDTH(8), .FRAME_LEN(4), .FCW(16)) ifb ();
    parity_frame_accum_if #(.WIDTH(8), .FRAME_LEN(1), .FCW(2))  ifc ();

    parity_frame_accum #(.WIDTH(8), .FRAME_LEN(4), .ODD(0), .FCW(16)) u_a (
        .clk(clk), .rst(rst), .bus(ifa));
    parity_frame_accum #(.WIDTH(8), .FRAME_LEN(4), .ODD(1), .FCW(16)) u_b (
        .clk(clk), .rst(rst), .bus(ifb));
    parity_frame_accum #(.WIDTH(8), .FRAME_LEN(1), .ODD(0), .FCW(2)) u_c (
        .clk(clk), .rst(rst), .bus(ifc));

    int         sel = 0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    assign ifa.in_valid  = in_valid && (sel == 0);
    assign ifb.in_valid  = in_valid && (sel == 1);
    assign ifc.in_valid  = in_valid && (sel == 2);
    assign ifa.out_ready = out_ready && (sel == 0);
    assign ifb.out_ready = out_ready && (sel == 1);
    assign ifc.out_ready = out_ready && (sel == 2);
    assign ifa.in_data = in_data;
    assign ifb.in_data = in_data;
    assign ifc.in_data = in_data;
    assign ifa.in_last = in_last;
    assign ifb.in_last = in_last;
    assign ifc.in_last = in_last;

    logic        m_in_ready, m_out_valid, m_parity;
    logic [2:0]  m_words;
    logic [15:0] m_fc;

    assign m_in_ready  = (sel == 0) ? ifa.in_ready :
                         (sel == 1) ? ifb.in_ready : ifc.in_ready;
    assign m_out_valid = (sel == 0) ? ifa.out_valid :
                         (sel == 1) ? ifb.out_valid : ifc.out_valid;
    assign m_parity    = (sel == 0) ? ifa.out_parity :
                         (sel == 1) ? ifb.out_parity : ifc.out_parity;
    assign m_words     = (sel == 0) ? ifa.out_words :
                         (sel == 1) ? ifb.out_words : 3'(ifc.out_words);
    assign m_fc        = (sel == 0) ? ifa.frame_cnt :
                         (sel == 1) ? ifb.frame_cnt : 16'(ifc.frame_cnt);

    int flen_of[3] = '{4, 4, 1};
    int odd_of[3]  = '{0, 1, 0};
    int fcmod_of[3] = '{65536, 65536, 4};
    int fc_model[3] = '{0, 0, 0};

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int              sel;
        int              n;
        logic [3:0][7:0] d;
        logic [3:0]      last;
        logic            par;
        int              words;
    } vec_t;

    vec_t vecs[12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_idle(string tag);
        chk({tag, "_in_ready"}, 32'(m_in_ready), 1);
        chk({tag, "_out_valid"}, 32'(m_out_valid), 0);
        chk({tag, "_out_parity"}, 32'(m_parity), 0);
        chk({tag, "_out_words"}, 32'(m_words), 0);
        chk({tag, "_frame_cnt"}, 32'(m_fc), 0);
    endtask

    task automatic send_word(logic [7:0] d, logic last);
        int t;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        t = 0;
        while (!m_in_ready && t < 20) begin
            step();
            t++;
        end
        if (t == 20) chk("in_ready_timeout", 0, 1);
        step();
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic get_result(logic par, int words, int hold, string tag);
        int t;
        for (int k = 0; k < hold; k++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            step();
            chk({tag, "_hold_valid"}, 32'(m_out_valid), 1);
            chk({tag, "_hold_parity"}, 32'(m_parity), 32'(par));
            chk({tag, "_hold_words"}, 32'(m_words), words);
            chk({tag, "_hold_in_ready"}, 32'(m_in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        t = 0;
        while (!m_out_valid && t < 20) begin
            step();
            t++;
        end
        if (t == 20) chk({tag, "_result_timeout"}, 0, 1);
        chk({tag, "_parity"}, 32'(m_parity), 32'(par));
        chk({tag, "_words"}, 32'(m_words), words);
        step();
        out_ready = 1'b0;
        fc_model[sel] = (fc_model[sel] + 1) % fcmod_of[sel];
        chk({tag, "_frame_cnt"}, 32'(m_fc), fc_model[sel]);
        chk({tag, "_valid_drop"}, 32'(m_out_valid), 0);
        chk({tag, "_ready_back"}, 32'(m_in_ready), 1);
    endtask

    task automatic async_reset(string tag);
        #2 rst = 1'b1;
        #1;
        check_idle(tag);
        #2 rst = 1'b0;
        step();
        fc_model = '{0, 0, 0};
    endtask

    task automatic random_frames(int s, int nframes);
        int cnt, ones, idle;
        logic [7:0] d;
        logic last;
        sel = s;
        for (int f = 0; f < nframes; f++) begin
            cnt = 0;
            ones = 0;
            forever begin
                idle = $urandom_range(0, 2);
                for (int k = 0; k < idle; k++) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    in_last  = 1'b1;
                    step();
                end
                d = 8'($urandom);
                last = ($urandom_range(0, 3) == 0);
                send_word(d, last);
                cnt++;
                ones += $countones(d);
                if (cnt == flen_of[s] || last) break;
            end
            chk($sformatf("rnd%0d_latency", s), 32'(m_out_valid), 1);
            get_result(1'((ones % 2) ^ odd_of[s]), cnt,
                       $urandom_range(0, 3), $sformatf("rnd%0d", s));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wrap_exp[5];
        int ones;
        logic [7:0] d;
        wrap_exp = '{1, 2, 3, 0, 1};

        vecs[0]  = '{0, 4, 32'h00070301, 4'b0000, 1'b0, 4};
        vecs[1]  = '{0, 2, 32'h00000301, 4'b0010, 1'b1, 2};
        vecs[2]  = '{0, 1, 32'h000000FF, 4'b0001, 1'b0, 1};
        vecs[3]  = '{0, 4, 32'h00000080, 4'b0000, 1'b1, 4};
        vecs[4]  = '{0, 4, 32'h04020107, 4'b1000, 1'b0, 4};
        vecs[5]  = '{0, 1, 32'h0000007F, 4'b0001, 1'b1, 1};
        vecs[6]  = '{0, 3, 32'h00FE110F, 4'b0100, 1'b1, 3};
        vecs[7]  = '{1, 4, 32'h00070301, 4'b0000, 1'b1, 4};
        vecs[8]  = '{1, 4, 32'h00000080, 4'b0000, 1'b0, 4};
        vecs[9]  = '{1, 2, 32'h00000301, 4'b0010, 1'b0, 2};
        vecs[10] = '{2, 1, 32'h00000003, 4'b0000, 1'b0, 1};
        vecs[11] = '{2, 1, 32'h00000001, 4'b0001, 1'b1, 1};

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        step();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_idle($sformatf("reset%0d", s));
        end

        for (int v = 0; v < 12; v++) begin
            sel = vecs[v].sel;
            for (int i = 0; i < vecs[v].n; i++)
                send_word(vecs[v].d[i], vecs[v].last[i]);
            chk($sformatf("vec%0d_latency", v), 32'(m_out_valid), 1);
            chk($sformatf("vec%0d_blocked", v), 32'(m_in_ready), 0);
            get_result(vecs[v].par, vecs[v].words, 0,
                       $sformatf("vec%0d", v));
        end

        // backpressure with a word waiting through the handshake edge
        sel = 0;
        send_word(8'h01, 1'b0);
        send_word(8'h03, 1'b0);
        send_word(8'h07, 1'b0);
        send_word(8'h00, 1'b0);
        in_valid  = 1'b1;
        in_data   = 8'h01;
        in_last   = 1'b1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_in_ready", k), 32'(m_in_ready), 0);
            chk($sformatf("bp%0d_valid", k), 32'(m_out_valid), 1);
            chk($sformatf("bp%0d_parity", k), 32'(m_parity), 0);
            chk($sformatf("bp%0d_words", k), 32'(m_words), 4);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        fc_model[0]++;
        chk("bp_hs_valid", 32'(m_out_valid), 0);
        chk("bp_hs_in_ready", 32'(m_in_ready), 1);
        chk("bp_hs_frame_cnt", 32'(m_fc), fc_model[0]);
        send_word(8'h01, 1'b1);
        get_result(1'b1, 1, 0, "bp_next");

        random_frames(0, 40);
        random_frames(1, 15);
        random_frames(2, 10);

        // reset while a result is pending
        sel = 0;
        send_word(8'h80, 1'b1);
        chk("hold_pre_reset_valid", 32'(m_out_valid), 1);
        async_reset("rst_hold");

        // reset mid-frame discards the partial frame
        send_word(8'h01, 1'b0);
        send_word(8'h01, 1'b0);
        async_reset("rst_mid");
        for (int i = 0; i < 4; i++) send_word(8'hFF, 1'b0);
        get_result(1'b0, 4, 0, "rst_ff");
        chk("rst_ff_frame_cnt_one", 32'(m_fc), 1);

        // frame counter wrap on the FCW=2, FRAME_LEN=1 instance
        sel = 2;
        async_reset("rst_wrap");
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            ones = $countones(d);
            send_word(d, 1'($urandom));
            get_result(1'(ones % 2), 1, 0, $sformatf("wrap%0d", i));
            chk($sformatf("wrap%0d_seq", i), 32'(m_fc), wrap_exp[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/parity_frame_accum.md
# parity_frame_accum

Parametrised successor to the team's fixed 3-input XOR parity cell. The block accumulates running XOR parity across a stream of WIDTH-bit words, grouped into frames of up to FRAME_LEN words, and emits one parity result per frame over a valid/ready handshake. An ODD parameter selects even or odd parity. It sits between a word source and a frame consumer, such as a link packetiser or a checker that compares against a received parity bit.

## Interface
Parameters:
- WIDTH, 8: data word width in bits (≥1).
- FRAME_LEN, 4: maximum words per frame (≥1).
- ODD, 0: 0 = even parity result; 1 = odd parity result (result inverted).
- FCW, 16: width of the completed-frame counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  input word.
- in_last  in  1  marks the final word of a short frame; sampled only on accept.
- out_valid  out  1  frame result present.
- out_ready  in  1  consumer accepts the result.
- out_parity  out  1  frame parity result.
- out_words  out  CW  number of words in the frame, where CW = $clog2(FRAME_LEN+1).
- frame_cnt  out  FCW  completed frames (handshaken results), wraps modulo 2^FCW.

## Operation
- States: ACC (collecting words) and HOLD (result pending).
- Accept occurs when in_valid && in_ready. in_ready = 1 in ACC and 0 in HOLD.
- On accept in ACC:
  - acc ← acc ^ (^in_data);
  - cnt ← cnt + 1.
- End of frame occurs on an accept where cnt == FRAME_LEN-1 or in_last == 1. On that accept:
  - state → HOLD;
  - out_parity ← acc ^ (^in_data) ^ ODD;
  - out_words ← cnt + 1;
  - acc and cnt are cleared.
- In HOLD:
  - out_valid = 1.
  - out_parity and out_words are held stable until out_ready is sampled high.
  - On out_valid && out_ready: state → ACC, out_valid ← 0, frame_cnt ← frame_cnt + 1 (wrap 2^FCW − 1 → 0).
- No input bypass: a word is never accepted in the same cycle the result is handshaken. in_ready rises on the cycle after the output handshake.
- in_last on a word where cnt is already FRAME_LEN-1 is redundant. It ends the frame once, with no empty frame.
- in_data and in_last are ignored when no accept occurs.
- FRAME_LEN = 1: every accepted word is a frame, out_words = 1.
- Reset (asynchronous, any state, including mid-frame):
  - state = ACC;
  - acc = 0, cnt = 0;
  - in_ready = 1, out_valid = 0, out_parity = 0, out_words = 0, frame_cnt = 0.
  - Partial frame contents are discarded.

## Timing
- All outputs are registered, except in_ready, which is decoded from state (registered-state-only, no combinational path from any input).
- Latency: out_valid rises 1 cycle after the final word's accept edge.
- Throughput:
  - A frame of N words costs N accept cycles plus at least 1 HOLD cycle.
  - With out_ready tied high, the sustained rate is N words per N+1 cycles.
- out_valid never drops without a handshake (except on reset).
- Output fields are stable while out_valid && !out_ready.
- frame_cnt updates on the edge that completes the output handshake.

## Test plan
- Full frame, even parity (WIDTH=8, FRAME_LEN=4, ODD=0):
  - Stimulus: accept 0x01, 0x03, 0x07, 0x00 on consecutive cycles, out_ready=1.
  - Response: out_valid=1 the cycle after the 4th accept, out_parity=0, out_words=4; frame_cnt=1 after the handshake.
- Short frame via in_last:
  - Stimulus: 0x01, then 0x03 with in_last=1.
  - Response: out_parity=1, out_words=2; the next word is accepted only after the handshake.
- Odd mode (ODD=1):
  - Stimulus: same 4 words as the first scenario.
  - Response: out_parity=1.
  - Stimulus: 0x80, 0x00, 0x00, 0x00.
  - Response: out_parity=0.
- Backpressure:
  - Stimulus: complete a frame, then hold out_ready=0 for 5 cycles with in_valid=1.
  - Response: in_ready=0 and out_valid/out_parity/out_words unchanged for all 5 cycles; raising out_ready gives one handshake, then in_ready=1 the next cycle.
- Reset mid-frame:
  - Stimulus: accept 0x01, 0x01, then pulse rst asynchronously between edges.
  - Response: all outputs take reset values immediately.
  - Stimulus: then send 0xFF ×4.
  - Response: out_parity=0, out_words=4, frame_cnt=1 after the handshake.
- Counter wrap (FCW=2, FRAME_LEN=1):
  - Stimulus: 5 single-word frames, all handshaken.
  - Response: frame_cnt sequence 1, 2, 3, 0, 1.
